// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcode constants and the fetch/decode entry format.
// Used by fetch_unit and fetch_fifo.
package cpu_pkg;

   localparam int         PC_W       = 8;
   localparam int         INSTR_W    = 16;
   localparam logic [3:0] OPC_BRANCH = 4'hC;

   // One fetched instruction as carried from fetch to decode.
   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
      logic               pred_taken;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: in-order fetch buffer with the head entry exposed combinationally.
// Ports:
//   clk, reset         clock, async active-high reset (empties buffer, zeroes storage)
//   i_push / i_wdata   write an entry (ignored when full unless popping the same cycle)
//   i_pop              drop the head entry (ignored when empty)
//   i_clear            synchronous empty; wins over push and pop
//   o_full / o_empty   occupancy flags
//   o_head             entry at the read pointer
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int  DEPTH = 2,
   parameter type T     = fetch_entry_t
) (
   input  logic clk,
   input  logic reset,
   input  logic i_push,
   input  logic i_pop,
   input  logic i_clear,
   input  T     i_wdata,
   output logic o_full,
   output logic o_empty,
   output T     o_head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   T                 r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_push;
   logic w_pop;

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rd_ptr];

   // A push into a full buffer is allowed when the head leaves in the same
   // cycle; the slot being written is the one being vacated.
   assign w_pop  = i_pop && !o_empty;
   assign w_push = i_push && (!o_full || w_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
         end
         if (w_pop)
            r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
         if (w_push && !w_pop)
            r_count <= r_count + CNT_W'(1);
         else if (w_pop && !w_push)
            r_count <= r_count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC register, next-PC selection with static branch prediction,
// and the fetch buffer feeding decode.
// Ports:
//   clk, reset                     clock, async active-high reset
//   o_imem_addr / i_imem_data      instruction memory (combinational read)
//   o_bp_pc / i_predict_taken /
//   i_pred_target                  branch predictor lookup for the current PC
//   i_flush / i_redirect_pc        misprediction recovery
//   o_fd_valid / i_fd_ready        fetch-to-decode handshake
//   o_fd_instr / o_fd_pc /
//   o_fd_pred_taken                head entry of the fetch buffer
module fetch_unit
   import cpu_pkg::*;
#(
   // Widths must match cpu_pkg, which fixes the layout of fetch_entry_t.
   parameter int PC_W       = cpu_pkg::PC_W,
   parameter int INSTR_W    = cpu_pkg::INSTR_W,
   parameter int FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               reset,
   output logic [PC_W-1:0]    o_imem_addr,
   input  logic [INSTR_W-1:0] i_imem_data,
   output logic [PC_W-1:0]    o_bp_pc,
   input  logic               i_predict_taken,
   input  logic [PC_W-1:0]    i_pred_target,
   input  logic               i_flush,
   input  logic [PC_W-1:0]    i_redirect_pc,
   output logic               o_fd_valid,
   input  logic               i_fd_ready,
   output logic [INSTR_W-1:0] o_fd_instr,
   output logic [PC_W-1:0]    o_fd_pc,
   output logic               o_fd_pred_taken
);

   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] w_next_pc;
   logic            w_is_branch;
   logic            w_taken;
   logic            w_pop;
   logic            w_do_fetch;
   logic            w_full;
   logic            w_empty;
   fetch_entry_t    w_push_entry;
   fetch_entry_t    w_head;

   assign o_imem_addr = r_pc;
   assign o_bp_pc     = r_pc;

   assign w_is_branch = (i_imem_data[INSTR_W-1 -: 4] == OPC_BRANCH);
   // Predictor output only matters for real branch opcodes.
   assign w_taken     = w_is_branch && i_predict_taken;
   assign w_pop       = o_fd_valid && i_fd_ready;
   assign w_do_fetch  = !i_flush && (!w_full || w_pop);
   assign w_next_pc   = w_taken ? i_pred_target : r_pc + PC_W'(1);

   assign w_push_entry = '{pc: r_pc, instr: i_imem_data, pred_taken: w_taken};

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_pc <= '0;
      else if (i_flush)
         r_pc <= i_redirect_pc;
      else if (w_do_fetch)
         r_pc <= w_next_pc;
   end

   // Flush drives clear, which overrides the pop the handshake may signal.
   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (fetch_entry_t)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_do_fetch),
      .i_pop   (w_pop),
      .i_clear (i_flush),
      .i_wdata (w_push_entry),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

   assign o_fd_valid      = !w_empty;
   assign o_fd_instr      = w_head.instr;
   assign o_fd_pc         = w_head.pc;
   assign o_fd_pred_taken = w_head.pred_taken;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed tests for fetch_unit. Instruction memory holds
// 16'h10xx (non-branch, low byte = address) except where a test plants a word.
module tb_fetch_unit;

   logic        clk;
   logic        reset;
   logic [7:0]  imem_addr;
   logic [15:0] imem_data;
   logic [7:0]  bp_pc;
   logic        predict_taken;
   logic [7:0]  pred_target;
   logic        flush;
   logic [7:0]  redirect_pc;
   logic        fd_valid;
   logic        fd_ready;
   logic [15:0] fd_instr;
   logic [7:0]  fd_pc;
   logic        fd_pred_taken;

   logic [15:0] imem [256];
   int checks;
   int failures;

   assign imem_data = imem[imem_addr];

   fetch_unit #(.PC_W(8), .INSTR_W(16), .FIFO_DEPTH(2)) dut (
      .clk             (clk),
      .reset           (reset),
      .o_imem_addr     (imem_addr),
      .i_imem_data     (imem_data),
      .o_bp_pc         (bp_pc),
      .i_predict_taken (predict_taken),
      .i_pred_target   (pred_target),
      .i_flush         (flush),
      .i_redirect_pc   (redirect_pc),
      .o_fd_valid      (fd_valid),
      .i_fd_ready      (fd_ready),
      .o_fd_instr      (fd_instr),
      .o_fd_pc         (fd_pc),
      .o_fd_pred_taken (fd_pred_taken)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Hold reset over one edge, then release just after an edge.
   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; fd_ready = 1'b1;
      predict_taken = 1'b0; pred_target = 8'h00; redirect_pc = 8'h00;
      step();
      checks++;
      if ({fd_valid, fd_pc, fd_instr, fd_pred_taken} !== 26'h0) begin
         failures++;
         $display("FAIL reset_fd got v=%b pc=%h i=%h p=%b want all zero",
                  fd_valid, fd_pc, fd_instr, fd_pred_taken);
      end
      checks++;
      if (imem_addr !== 8'h00 || bp_pc !== 8'h00) begin
         failures++;
         $display("FAIL reset_pc got addr=%h bp=%h want 00", imem_addr, bp_pc);
      end
   endtask

   task automatic test_sequential();
      fd_ready = 1'b1; predict_taken = 1'b0;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         step();
         checks++;
         if ({fd_valid, fd_pc, fd_instr, fd_pred_taken} !==
             {1'b1, 8'(k), 8'h10, 8'(k), 1'b0}) begin
            failures++;
            $display("FAIL seq_%0d got v=%b pc=%h i=%h p=%b want v=1 pc=%h i=10%h p=0",
                     k, fd_valid, fd_pc, fd_instr, fd_pred_taken, 8'(k), 8'(k));
         end
      end
   endtask

   task automatic test_branch();
      fd_ready = 1'b1; predict_taken = 1'b1; pred_target = 8'h40;
      do_reset();
      for (int k = 0; k < 5; k++) step();
      // PC 4 is a non-branch fetched with predict_taken=1
      checks++;
      if (imem_addr !== 8'h05 || fd_pc !== 8'h04 || fd_pred_taken !== 1'b0) begin
         failures++;
         $display("FAIL br_pre got addr=%h fd_pc=%h p=%b want 05 04 0",
                  imem_addr, fd_pc, fd_pred_taken);
      end
      step();
      checks++;
      if (imem_addr !== 8'h40 || bp_pc !== 8'h40) begin
         failures++;
         $display("FAIL br_target got addr=%h bp=%h want 40", imem_addr, bp_pc);
      end
      checks++;
      if ({fd_valid, fd_pc, fd_instr, fd_pred_taken} !== {1'b1, 8'h05, 16'hC012, 1'b1}) begin
         failures++;
         $display("FAIL br_entry got v=%b pc=%h i=%h p=%b want 1 05 c012 1",
                  fd_valid, fd_pc, fd_instr, fd_pred_taken);
      end
      step();
      checks++;
      if (fd_pc !== 8'h40 || fd_pred_taken !== 1'b0 || imem_addr !== 8'h41) begin
         failures++;
         $display("FAIL br_after got fd_pc=%h p=%b addr=%h want 40 0 41",
                  fd_pc, fd_pred_taken, imem_addr);
      end
   endtask

   task automatic test_nonbranch_pt();
      fd_ready = 1'b1; predict_taken = 1'b1; pred_target = 8'h40;
      flush = 1'b1; redirect_pc = 8'h07;
      step();
      flush = 1'b0;
      checks++;
      if (fd_valid !== 1'b0 || imem_addr !== 8'h07) begin
         failures++;
         $display("FAIL nb_redirect got v=%b addr=%h want 0 07", fd_valid, imem_addr);
      end
      step();
      checks++;
      if (imem_addr !== 8'h08 || fd_pc !== 8'h07 || fd_instr !== 16'h1234 ||
          fd_pred_taken !== 1'b0) begin
         failures++;
         $display("FAIL nb_pt got addr=%h pc=%h i=%h p=%b want 08 07 1234 0",
                  imem_addr, fd_pc, fd_instr, fd_pred_taken);
      end
      predict_taken = 1'b0;
   endtask

   task automatic test_backpressure();
      fd_ready = 1'b0; predict_taken = 1'b0;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         step();
         checks++;
         if (fd_valid !== 1'b1 || fd_pc !== 8'h00 || fd_instr !== 16'h1000) begin
            failures++;
            $display("FAIL bp_hold_%0d got v=%b pc=%h i=%h want 1 00 1000",
                     k, fd_valid, fd_pc, fd_instr);
         end
      end
      checks++;
      if (imem_addr !== 8'h02) begin
         failures++;
         $display("FAIL bp_pc_held got addr=%h want 02", imem_addr);
      end
      fd_ready = 1'b1;
      step();
      checks++;
      if (fd_pc !== 8'h01 || imem_addr !== 8'h03) begin
         failures++;
         $display("FAIL bp_drain1 got pc=%h addr=%h want 01 03", fd_pc, imem_addr);
      end
      step();
      checks++;
      if (fd_pc !== 8'h02 || fd_valid !== 1'b1 || imem_addr !== 8'h04) begin
         failures++;
         $display("FAIL bp_drain2 got pc=%h v=%b addr=%h want 02 1 04",
                  fd_pc, fd_valid, imem_addr);
      end
   endtask

   // Continues from backpressure: buffer holds 02,03 and PC is 04.
   task automatic test_flush_full();
      fd_ready = 1'b0;
      step();
      checks++;
      if (fd_pc !== 8'h02 || imem_addr !== 8'h04) begin
         failures++;
         $display("FAIL fl_full_pre got pc=%h addr=%h want 02 04", fd_pc, imem_addr);
      end
      flush = 1'b1; redirect_pc = 8'h20;
      step();
      flush = 1'b0; fd_ready = 1'b1;
      checks++;
      if (fd_valid !== 1'b0 || imem_addr !== 8'h20) begin
         failures++;
         $display("FAIL fl_clear got v=%b addr=%h want 0 20", fd_valid, imem_addr);
      end
      step();
      checks++;
      if (fd_valid !== 1'b1 || fd_pc !== 8'h20) begin
         failures++;
         $display("FAIL fl_resume got v=%b pc=%h want 1 20", fd_valid, fd_pc);
      end
   endtask

   task automatic test_back_to_back_flush();
      fd_ready = 1'b1;
      flush = 1'b1; redirect_pc = 8'h30;
      step();
      redirect_pc = 8'h50;
      step();
      flush = 1'b0;
      checks++;
      if (fd_valid !== 1'b0 || imem_addr !== 8'h50) begin
         failures++;
         $display("FAIL b2b_flush got v=%b addr=%h want 0 50", fd_valid, imem_addr);
      end
      step();
      checks++;
      if (fd_pc !== 8'h50 || fd_instr !== 16'h1050) begin
         failures++;
         $display("FAIL b2b_resume got pc=%h i=%h want 50 1050", fd_pc, fd_instr);
      end
   endtask

   task automatic test_wrap_reset();
      fd_ready = 1'b0;
      flush = 1'b1; redirect_pc = 8'hFE;
      step();
      flush = 1'b0;
      step();
      step();
      checks++;
      if (imem_addr !== 8'h00 || fd_valid !== 1'b1 || fd_pc !== 8'hFE) begin
         failures++;
         $display("FAIL wrap got addr=%h v=%b pc=%h want 00 1 fe", imem_addr, fd_valid, fd_pc);
      end
      step();
      checks++;
      if (imem_addr !== 8'h00 || fd_pc !== 8'hFE) begin
         failures++;
         $display("FAIL wrap_full_hold got addr=%h pc=%h want 00 fe", imem_addr, fd_pc);
      end
      // Move PC off zero so the async reset is observable on the address.
      fd_ready = 1'b1;
      step();
      step();
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({fd_valid, fd_pc, fd_instr, fd_pred_taken} !== 26'h0 || imem_addr !== 8'h00) begin
         failures++;
         $display("FAIL async_reset got v=%b pc=%h i=%h p=%b addr=%h want zeros",
                  fd_valid, fd_pc, fd_instr, fd_pred_taken, imem_addr);
      end
      step();
      reset = 1'b0;
      step();
      checks++;
      if (fd_valid !== 1'b1 || fd_pc !== 8'h00 || imem_addr !== 8'h01) begin
         failures++;
         $display("FAIL post_reset got v=%b pc=%h addr=%h want 1 00 01",
                  fd_valid, fd_pc, imem_addr);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      for (int i = 0; i < 256; i++) imem[i] = 16'h1000 | 16'(i);
      imem[5] = 16'hC012;
      imem[7] = 16'h1234;
      reset = 1'b1; flush = 1'b0; fd_ready = 1'b0;
      predict_taken = 1'b0; pred_target = 8'h00; redirect_pc = 8'h00;
      test_reset();
      test_sequential();
      test_branch();
      test_nonbranch_pt();
      test_backpressure();
      test_flush_full();
      test_back_to_back_flush();
      test_wrap_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
